// File: rtl/enigma_pkg.sv
// enigma_pkg
//   Shared definitions for the single-rotor Enigma controller:
//   ASCII range constants, rotor modulus, FSM state encoding and the
//   rotor configuration reduction helper.
package enigma_pkg;

  localparam logic [7:0] CH_A  = 8'h41;
  localparam logic [7:0] CH_Z  = 8'h5A;
  localparam logic [7:0] CH_LA = 8'h61;
  localparam logic [7:0] CH_LZ = 8'h7A;

  localparam int ROTOR_MOD = 26;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    APPLY,
    CAPTURE,
    STEP,
    OUTPUT
  } state_t;

  // Rotor positions are 0..25; the 5-bit config field can also carry 26..31,
  // which fold back onto 0..5.
  function automatic logic [4:0] reduce_rotor(input logic [4:0] s);
    return (s >= 5'(ROTOR_MOD)) ? (s - 5'(ROTOR_MOD)) : s;
  endfunction

endpackage

// File: rtl/enigma_if.sv
// enigma_if
//   Keystroke and result handshakes of the Enigma controller.
//   key_valid/key_ascii/key_ready : key stream into the controller
//   out_valid/out_ascii/out_ready : processed characters out of it
//   Modports: master = key producer / result consumer, slave = controller.
interface enigma_if;
  logic       key_valid;
  logic [7:0] key_ascii;
  logic       key_ready;
  logic       out_valid;
  logic [7:0] out_ascii;
  logic       out_ready;

  modport master (
    output key_valid, key_ascii, out_ready,
    input  key_ready, out_valid, out_ascii
  );

  modport slave (
    input  key_valid, key_ascii, out_ready,
    output key_ready, out_valid, out_ascii
  );
endinterface

// File: rtl/enigma_ascii_normaliser.sv
// ascii_normaliser
//   Combinational key classifier. Lower-case letters are folded to upper
//   case; every other code passes through unchanged.
//   in_char    : raw ASCII key
//   is_letter  : key is 'A'..'Z' or 'a'..'z'
//   upper_char : upper-cased key (unchanged for non-letters)
module ascii_normaliser
  import enigma_pkg::*;
(
  input  logic [7:0] in_char,
  output logic       is_letter,
  output logic [7:0] upper_char
);

  always_comb begin
    is_letter  = 1'b0;
    upper_char = in_char;
    if (in_char >= CH_LA && in_char <= CH_LZ) begin
      is_letter  = 1'b1;
      upper_char = in_char - 8'h20;
    end else if (in_char >= CH_A && in_char <= CH_Z) begin
      is_letter  = 1'b1;
    end
  end

endmodule

// File: rtl/enigma_controller.sv
// enigma_controller
//   Sequences a single-rotor Enigma datapath one keystroke at a time.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     bus (enigma_if.slave): key input and result output handshakes
//     cfg_load/cfg_rotor_state/cfg_encrypt : rotor configuration request
//     busy                : high whenever the FSM is not idle
//     rotor_pos           : mirror of the datapath rotor position (0..25)
//     dp_*                : connections to the rotor/shifter datapath
//   Letters are held on dp_char_input for SETTLE_CYCLES, the datapath result
//   is captured, then the rotor is stepped. Non-letters bypass the datapath.
module enigma_controller
  import enigma_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       reset,
  enigma_if.slave    bus,
  input  logic       cfg_load,
  input  logic [4:0] cfg_rotor_state,
  input  logic       cfg_encrypt,
  output logic       busy,
  output logic [4:0] rotor_pos,
  output logic [7:0] dp_char_input,
  output logic       dp_encrypt,
  output logic       dp_char_pressed,
  output logic       dp_load_init_state,
  output logic [4:0] dp_rotor_init_state,
  input  logic [7:0] dp_letter_out
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             cfg_pending_reg;
  logic [4:0]       pend_state_reg;
  logic             pend_enc_reg;
  logic [4:0]       rotor_pos_reg;
  logic             enc_reg;
  logic [4:0]       init_state_reg;
  logic [7:0]       char_in_reg;
  logic [7:0]       out_ascii_reg;

  logic             key_is_letter;
  logic [7:0]       key_upper;
  logic             key_ready_w;
  logic             go_load;
  logic             accept;

  ascii_normaliser u_norm (
    .in_char    (bus.key_ascii),
    .is_letter  (key_is_letter),
    .upper_char (key_upper)
  );

  // Config requests win over keys in IDLE, whether fresh or deferred.
  assign go_load = (state_reg == IDLE) && (cfg_pending_reg || cfg_load);
  assign accept  = key_ready_w && bus.key_valid;

  always_comb begin
    state_next         = state_reg;
    key_ready_w        = 1'b0;
    busy               = 1'b1;
    bus.out_valid      = 1'b0;
    dp_char_pressed    = 1'b0;
    dp_load_init_state = 1'b0;
    case (state_reg)
      IDLE: begin
        busy        = 1'b0;
        key_ready_w = !(cfg_pending_reg || cfg_load);
        if (cfg_pending_reg || cfg_load) begin
          state_next = LOAD;
        end else if (bus.key_valid) begin
          state_next = key_is_letter ? APPLY : OUTPUT;
        end
      end
      LOAD: begin
        dp_load_init_state = 1'b1;
        state_next         = IDLE;
      end
      APPLY: begin
        if (cnt_reg == SETTLE_LAST) state_next = CAPTURE;
      end
      CAPTURE: state_next = STEP;
      STEP: begin
        dp_char_pressed = 1'b1;
        state_next      = OUTPUT;
      end
      OUTPUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      cfg_pending_reg <= 1'b0;
      pend_state_reg  <= '0;
      pend_enc_reg    <= 1'b1;
      rotor_pos_reg   <= '0;
      enc_reg         <= 1'b1;
      init_state_reg  <= '0;
      char_in_reg     <= '0;
      out_ascii_reg   <= '0;
    end else begin
      state_reg <= state_next;

      // A request arriving while busy (including during LOAD itself) is parked;
      // the newest request replaces any older parked one.
      if (cfg_load && state_reg != IDLE) begin
        cfg_pending_reg <= 1'b1;
        pend_state_reg  <= reduce_rotor(cfg_rotor_state);
        pend_enc_reg    <= cfg_encrypt;
      end else if (state_reg == LOAD) begin
        cfg_pending_reg <= 1'b0;
      end

      // Configuration values become visible as LOAD starts so the datapath
      // sees a consistent state/mode during its load pulse.
      if (go_load) begin
        init_state_reg <= cfg_load ? reduce_rotor(cfg_rotor_state) : pend_state_reg;
        rotor_pos_reg  <= cfg_load ? reduce_rotor(cfg_rotor_state) : pend_state_reg;
        enc_reg        <= cfg_load ? cfg_encrypt : pend_enc_reg;
      end

      if (accept) begin
        cnt_reg <= '0;
        if (key_is_letter) char_in_reg   <= key_upper;
        else               out_ascii_reg <= key_upper;
      end

      if (state_reg == APPLY)   cnt_reg       <= cnt_reg + CNT_W'(1);
      if (state_reg == CAPTURE) out_ascii_reg <= dp_letter_out;
      if (state_reg == STEP) begin
        rotor_pos_reg <= (rotor_pos_reg == 5'(ROTOR_MOD - 1)) ? 5'd0
                                                               : rotor_pos_reg + 5'd1;
      end
    end
  end

  assign bus.key_ready       = key_ready_w;
  assign bus.out_ascii       = out_ascii_reg;
  assign rotor_pos           = rotor_pos_reg;
  assign dp_char_input       = char_in_reg;
  assign dp_encrypt          = enc_reg;
  assign dp_rotor_init_state = init_state_reg;

endmodule

// File: tb/tb_enigma_controller.sv
// tb_enigma_controller
//   Directed plus randomized keystroke sequences against a Caesar-shift
//   datapath model and a keystroke-level reference model of the rotor.
module tb_enigma_controller;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_load;
  logic [4:0] cfg_rotor_state;
  logic       cfg_encrypt;
  logic       busy;
  logic [4:0] rotor_pos;
  logic [7:0] dp_char_input;
  logic       dp_encrypt;
  logic       dp_char_pressed;
  logic       dp_load_init_state;
  logic [4:0] dp_rotor_init_state;
  logic [7:0] dp_letter_out;

  enigma_if bus ();

  always #5 clk = ~clk;

  enigma_controller #(.SETTLE_CYCLES(S), .CNT_W(4)) dut (
    .clk                 (clk),
    .reset               (reset),
    .bus                 (bus),
    .cfg_load            (cfg_load),
    .cfg_rotor_state     (cfg_rotor_state),
    .cfg_encrypt         (cfg_encrypt),
    .busy                (busy),
    .rotor_pos           (rotor_pos),
    .dp_char_input       (dp_char_input),
    .dp_encrypt          (dp_encrypt),
    .dp_char_pressed     (dp_char_pressed),
    .dp_load_init_state  (dp_load_init_state),
    .dp_rotor_init_state (dp_rotor_init_state),
    .dp_letter_out       (dp_letter_out)
  );

  // Letter shift by rotor position: + when encrypting, - when decrypting.
  function automatic logic [7:0] caesar(input logic [7:0] c, input int rot, input logic enc);
    int idx;
    if (c < 8'h41 || c > 8'h5A) return c;
    idx = int'(c) - 65;
    idx = enc ? (idx + rot) % 26 : (idx - rot + 26) % 26;
    return 8'(idx + 65);
  endfunction

  // Datapath model: its own rotor, driven only by the controller's dp pins.
  logic [4:0] dp_rot = 5'd0;
  always @(posedge clk) begin
    if (dp_load_init_state)   dp_rot <= dp_rotor_init_state;
    else if (dp_char_pressed) dp_rot <= 5'((int'(dp_rot) + 1) % 26);
  end
  assign dp_letter_out = caesar(dp_char_input, int'(dp_rot), dp_encrypt);

  int   tests_run = 0;
  int   failed    = 0;
  int   m_pos     = 0;
  logic m_enc     = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int reduce(input logic [4:0] s);
    return (int'(s) >= 26) ? int'(s) - 26 : int'(s);
  endfunction

  task automatic do_cfg(input logic [4:0] cs, input logic ce);
    cfg_load = 1'b1; cfg_rotor_state = cs; cfg_encrypt = ce;
    #1;
    chk("cfg_key_ready_low", 32'(bus.key_ready), 0);
    tick();
    cfg_load = 1'b0;
    #1;
    chk("load_pulse", 32'(dp_load_init_state), 1);
    chk("load_init_state", 32'(dp_rotor_init_state), reduce(cs));
    chk("load_no_step", 32'(dp_char_pressed), 0);
    tick();
    m_pos = reduce(cs);
    m_enc = ce;
    chk("cfg_rotor_pos", 32'(rotor_pos), m_pos);
    chk("cfg_dp_encrypt", 32'(dp_encrypt), 32'(m_enc));
    chk("cfg_idle", 32'(busy), 0);
    $display("[TB] cfg state=%0d enc=%0d -> rotor_pos=%0d", cs, ce, rotor_pos);
  endtask

  // One keystroke. bp>0 holds out_ready low for bp OUTPUT cycles; with
  // cfg_in_bp two cfg_load pulses land during backpressure (the later wins).
  task automatic send_key(input logic [7:0] k, input int bp, input bit cfg_in_bp,
                          input logic [4:0] cs, input logic ce);
    logic [7:0] up;
    logic [7:0] exp_out;
    bit         letter;
    int         n;
    int         pulses;
    up      = (k >= 8'h61 && k <= 8'h7A) ? k - 8'h20 : k;
    letter  = (up >= 8'h41 && up <= 8'h5A);
    exp_out = letter ? caesar(up, m_pos, m_enc) : k;
    bus.key_valid = 1'b1; bus.key_ascii = k; bus.out_ready = (bp == 0);
    #1;
    chk("key_ready_idle", 32'(bus.key_ready), 1);
    tick();
    bus.key_valid = 1'b0; bus.key_ascii = 8'($urandom);
    #1;
    n = 1; pulses = 0;
    while (!bus.out_valid && n < 40) begin
      if (letter && n <= S) chk("dp_char_input", 32'(dp_char_input), 32'(up));
      if (dp_char_pressed) pulses++;
      tick();
      n++;
    end
    chk("latency", n, letter ? S + 3 : 1);
    chk("out_ascii", 32'(bus.out_ascii), 32'(exp_out));
    if (letter) m_pos = (m_pos + 1) % 26;
    chk("step_pulses", pulses, letter ? 1 : 0);
    chk("rotor_pos", 32'(rotor_pos), m_pos);
    for (int i = 0; i < bp; i++) begin
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_out_ascii", 32'(bus.out_ascii), 32'(exp_out));
      chk("bp_key_ready", 32'(bus.key_ready), 0);
      if (cfg_in_bp && i == 1) begin
        cfg_load = 1'b1; cfg_rotor_state = cs ^ 5'h0B; cfg_encrypt = ~ce;
      end else if (cfg_in_bp && i == 3) begin
        cfg_load = 1'b1; cfg_rotor_state = cs; cfg_encrypt = ce;
      end
      tick();
      cfg_load = 1'b0;
      #1;
    end
    bus.out_ready = 1'b1;
    tick();
    chk("out_valid_drop", 32'(bus.out_valid), 0);
    chk("back_idle", 32'(busy), 0);
    if (cfg_in_bp) begin
      chk("deferred_key_ready", 32'(bus.key_ready), 0);
      tick();
      chk("deferred_load", 32'(dp_load_init_state), 1);
      chk("deferred_init_state", 32'(dp_rotor_init_state), reduce(cs));
      tick();
      m_pos = reduce(cs);
      m_enc = ce;
      chk("deferred_rotor_pos", 32'(rotor_pos), m_pos);
      chk("deferred_encrypt", 32'(dp_encrypt), 32'(m_enc));
    end
    $display("[TB] key 0x%02h -> out 0x%02h (expect 0x%02h) latency=%0d rotor_pos=%0d",
             k, bus.out_ascii, exp_out, n, rotor_pos);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_rotor_state = '0; cfg_encrypt = 1'b1;
    bus.key_valid = 1'b0; bus.key_ascii = '0; bus.out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("rst_key_ready", 32'(bus.key_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_ascii", 32'(bus.out_ascii), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rotor_pos", 32'(rotor_pos), 0);
    chk("rst_dp_encrypt", 32'(dp_encrypt), 1);
    chk("rst_dp_char_input", 32'(dp_char_input), 0);
    chk("rst_dp_char_pressed", 32'(dp_char_pressed), 0);
    chk("rst_dp_load", 32'(dp_load_init_state), 0);
    chk("rst_dp_init_state", 32'(dp_rotor_init_state), 0);

    send_key(8'h41, 0, 1'b0, 5'd0, 1'b1);
    do_cfg(5'd3, 1'b1);
    send_key(8'h41, 0, 1'b0, 5'd0, 1'b1);          // 'A' at rotor 3 -> 'D'
    do_cfg(5'd25, 1'b1);
    send_key(8'h62, 0, 1'b0, 5'd0, 1'b1);          // 'b', rotor 25 wraps to 0
    send_key(8'h35, 0, 1'b0, 5'd0, 1'b1);          // '5' bypasses datapath
    do_cfg(5'd30, 1'b1);                           // 30 folds to 4
    send_key(8'h48, 5, 1'b1, 5'd7, 1'b0);          // backpressure + deferred cfg

    // Simultaneous cfg_load and key: LOAD goes first, key is not taken.
    bus.key_valid = 1'b1; bus.key_ascii = 8'h51;
    cfg_load = 1'b1; cfg_rotor_state = 5'd28; cfg_encrypt = 1'b1;
    #1;
    chk("simul_key_ready", 32'(bus.key_ready), 0);
    tick();
    cfg_load = 1'b0; bus.key_valid = 1'b0;
    #1;
    chk("simul_load_first", 32'(dp_load_init_state), 1);
    tick();
    m_pos = 2; m_enc = 1'b1;
    chk("simul_rotor_pos", 32'(rotor_pos), 2);
    $display("[TB] simultaneous cfg/key -> rotor_pos=%0d", rotor_pos);
    send_key(8'h51, 0, 1'b0, 5'd0, 1'b1);

    // Reset in APPLY aborts the keystroke without stepping the rotor.
    bus.key_valid = 1'b1; bus.key_ascii = 8'h4D; bus.out_ready = 1'b1;
    tick();
    bus.key_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_key_ready", 32'(bus.key_ready), 1);
    chk("abort_rotor_pos", 32'(rotor_pos), 0);
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_step", 32'(dp_char_pressed), 0);
      tick();
    end
    $display("[TB] reset in APPLY -> idle, no step");
    do_cfg(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));

    for (int t = 0; t < 24; t++) begin
      logic [7:0] k;
      int         cls;
      int         bp;
      if ($urandom_range(0, 5) == 0)
        do_cfg(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      cls = $urandom_range(0, 2);
      if (cls == 0)      k = 8'($urandom_range(8'h41, 8'h5A));
      else if (cls == 1) k = 8'($urandom_range(8'h61, 8'h7A));
      else               k = 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 6) : 0;
      send_key(k, bp, (bp > 0) && ($urandom_range(0, 1) == 1),
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
